// File: rtl/dpm_pkg.sv
// Shared types for duty_period_meter: FSM state encoding and the published result record.
package dpm_pkg;

    localparam int unsigned DpmCntW = 16;

    typedef enum logic [1:0] {
        StIdle,
        StArm,
        StHigh,
        StLow
    } dpm_state_e;

    typedef struct packed {
        logic [DpmCntW-1:0] period;
        logic [DpmCntW-1:0] high_time;
    } dpm_result_t;

endpackage

// File: rtl/dpm_sync_edge.sv
// Synchronizer and rise/fall detector for duty_period_meter.
// Defining DPM_GLITCH_FILTER_EN inserts a FILT_LEN-cycle stability filter after the synchronizer.
module dpm_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_LEN    = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_i,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   sync_lvl;
    logic                   s;
    logic                   s_dly_q, s_dly_d;

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], sig_i};
        s_dly_d = s;
    end

    assign sync_lvl = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            s_dly_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            s_dly_q <= s_dly_d;
        end
    end

`ifdef DPM_GLITCH_FILTER_EN
    localparam int unsigned FiltW = $clog2(FILT_LEN + 1);

    logic [FiltW-1:0] filt_cnt_q, filt_cnt_d;
    logic             filt_q, filt_d;

    // Counts consecutive cycles the synchronized level disagrees with the filtered level.
    always_comb begin
        filt_d     = filt_q;
        filt_cnt_d = '0;
        if (sync_lvl != filt_q) begin
            if (filt_cnt_q == FiltW'(FILT_LEN - 1)) begin
                filt_d = sync_lvl;
            end else begin
                filt_cnt_d = filt_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_q     <= 1'b0;
            filt_cnt_q <= '0;
        end else begin
            filt_q     <= filt_d;
            filt_cnt_q <= filt_cnt_d;
        end
    end

    assign s = filt_q;
`else
    assign s = sync_lvl;
`endif

    assign rise_o = s & ~s_dly_q;
    assign fall_o = ~s & s_dly_q;

endmodule

// File: rtl/duty_period_meter.sv
// Measures period and high time of a slow input; one {period, high_time} per rise-to-rise cycle.
// Optional glitch filter enabled by defining DPM_GLITCH_FILTER_EN.
module duty_period_meter #(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_LEN    = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sig_in,
    output logic             meas_valid,
    input  logic             meas_ready,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             overrun,
    output logic             timeout
);

    import dpm_pkg::*;

    typedef struct packed {
        logic [CNT_W-1:0] period;
        logic [CNT_W-1:0] high_time;
    } meas_t;

    localparam logic [CNT_W-1:0] CntMax = '1;

    logic       rise, fall;
    dpm_state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] high_cap_q, high_cap_d;
    meas_t      res_q, res_d;
    logic       meas_valid_q, meas_valid_d;
    logic       overrun_q, overrun_d;
    logic       timeout_q, timeout_d;
    logic       en_q, en_d;
    logic       publish;
    logic       accept;

    dpm_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILT_LEN    (FILT_LEN)
    ) u_sync_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .sig_i  (sig_in),
        .rise_o (rise),
        .fall_o (fall)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        high_cap_d   = high_cap_q;
        res_d        = res_q;
        meas_valid_d = meas_valid_q;
        overrun_d    = overrun_q;
        timeout_d    = timeout_q;
        en_d         = en;
        publish      = 1'b0;
        accept       = meas_valid_q & meas_ready;

        if (accept) begin
            meas_valid_d = 1'b0;
        end

        if (!en) begin
            // Partial measurement is dropped; a pending result stays valid.
            state_d = StIdle;
            cnt_d   = '0;
            if (en_q) begin
                overrun_d = 1'b0;
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d = StArm;
                    cnt_d   = '0;
                end
                StArm: begin
                    cnt_d = '0;
                    if (rise) begin
                        state_d = StHigh;
                        cnt_d   = CNT_W'(1);
                    end
                end
                StHigh, StLow: begin
                    if (cnt_q == CntMax) begin
                        timeout_d = 1'b1;
                        state_d   = StArm;
                        cnt_d     = '0;
                    end else if (state_q == StHigh && fall) begin
                        high_cap_d = cnt_q;
                        state_d    = StLow;
                        cnt_d      = cnt_q + 1'b1;
                    end else if (state_q == StLow && rise) begin
                        publish = 1'b1;
                        state_d = StHigh;
                        cnt_d   = CNT_W'(1);
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        if (publish) begin
            if (!meas_valid_q || accept) begin
                res_d.period    = cnt_q;
                res_d.high_time = high_cap_q;
                meas_valid_d    = 1'b1;
                timeout_d       = 1'b0;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            high_cap_q   <= '0;
            res_q        <= '0;
            meas_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
            timeout_q    <= 1'b0;
            en_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            high_cap_q   <= high_cap_d;
            res_q        <= res_d;
            meas_valid_q <= meas_valid_d;
            overrun_q    <= overrun_d;
            timeout_q    <= timeout_d;
            en_q         <= en_d;
        end
    end

    assign meas_valid = meas_valid_q;
    assign period     = res_q.period;
    assign high_time  = res_q.high_time;
    assign overrun    = overrun_q;
    assign timeout    = timeout_q;

endmodule
